// File: rtl/cursor_position.sv
// rtl/cursor_position.sv - per-frame cursor position from relative mouse packets
module cursor_position #(
  parameter int H      = 480,
  parameter int W      = 640,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  input  logic        x_ovf,
  input  logic        y_ovf,
  input  logic        btn_left,
  input  logic        frame_start,
  output logic [10:0] cursorX,
  output logic [10:0] cursorY,
  output logic        click,
  output logic        btn_held
);

  typedef enum logic [1:0] {IDLE, ACCUM, APPLY, CLAMP} state_t;

  localparam logic signed [12:0] X_MAX = 13'(W - 1);
  localparam logic signed [12:0] Y_MAX = 13'(H - 1);

  state_t             state, state_nxt;
  logic signed [11:0] acc_x, acc_y;
  logic signed [11:0] snap_x, snap_y;
  logic               snap_click;
  logic               click_pend;
  logic signed [12:0] sx, sy;
  logic               xfer, commit, press, pending;

  // 12-bit signed accumulate with saturation instead of wrap
  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic [8:0] d);
    logic signed [12:0] s;
    s = {a[11], a} + {{4{d[8]}}, d};
    if (s > 13'sd2047)
      return 12'sd2047;
    else if (s < -13'sd2048)
      return -12'sd2048;
    else
      return s[11:0];
  endfunction

  // Clamp a 13-bit signed screen coordinate into 0..max
  function automatic logic [10:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] max);
    if (v < 13'sd0)
      return 11'd0;
    else if (v > max)
      return max[10:0];
    else
      return v[10:0];
  endfunction

  // Handshake and event decode from the current state
  always_comb begin
    pkt_ready = (state == IDLE) || (state == ACCUM);
    xfer      = pkt_valid && pkt_ready;
    commit    = (state == ACCUM) && frame_start;
    press     = xfer && btn_left && !btn_held;
    pending   = (acc_x != 12'sd0) || (acc_y != 12'sd0) || click_pend;
  end

  // Next-state logic; frame_start is only honoured in ACCUM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = ACCUM;
      ACCUM:   if (frame_start) state_nxt = APPLY;
      APPLY:   state_nxt = CLAMP;
      CLAMP:   state_nxt = pending ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Accumulation, snapshot and the two-stage commit datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x      <= '0;
      acc_y      <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_click <= 1'b0;
      click_pend <= 1'b0;
      btn_held   <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      click      <= 1'b0;
      cursorX    <= 11'(X_INIT);
      cursorY    <= 11'(Y_INIT);
    end else begin
      if (commit) begin
        snap_x     <= acc_x;
        snap_y     <= acc_y;
        snap_click <= click_pend;
      end

      // A packet landing on the commit cycle starts the fresh accumulators
      if (xfer && !x_ovf)
        acc_x <= sat_add(commit ? 12'sd0 : acc_x, dx);
      else if (commit)
        acc_x <= '0;

      if (xfer && !y_ovf)
        acc_y <= sat_add(commit ? 12'sd0 : acc_y, dy);
      else if (commit)
        acc_y <= '0;

      if (commit)
        click_pend <= press;
      else if (press)
        click_pend <= 1'b1;

      if (xfer)
        btn_held <= btn_left;

      // Screen Y grows downward while mouse dy is positive-up
      if (state == APPLY) begin
        sx <= {2'b00, cursorX} + {snap_x[11], snap_x};
        sy <= {2'b00, cursorY} - {snap_y[11], snap_y};
      end

      click <= (state == CLAMP) ? snap_click : 1'b0;

      if (state == CLAMP) begin
        cursorX <= clamp(sx, X_MAX);
        cursorY <= clamp(sy, Y_MAX);
      end
    end
  end

endmodule
